// File: rtl/i2c_target_if.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte-wise write strobes and read fetch, open-drain SDA drive without clock stretching.
module i2c_target_if #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_next,
    input  logic [7:0] tx_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_DATA,
        ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } state_t;

    logic   r_scl_s1, r_scl_s2, r_scl_h;
    logic   r_sda_s1, r_sda_s2, r_sda_h;
    state_t r_state, w_state_nxt;
    logic [7:0] r_shift, w_shift_nxt, w_shift_in;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic       r_busy, w_busy_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       r_rw, w_rw_nxt;
    logic       w_tx_next;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop;

    // Synchronizers idle high so reset never fakes a bus edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_h <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_h <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i; r_scl_s2 <= r_scl_s1; r_scl_h <= r_scl_s2;
            r_sda_s1 <= sda_i; r_sda_s2 <= r_sda_s1; r_sda_h <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall = ~r_scl_s2 & r_scl_h;
    assign w_start    = ~r_sda_s2 & r_sda_h & r_scl_s2;
    assign w_stop     = r_sda_s2 & ~r_sda_h & r_scl_s2;
    assign w_shift_in = {r_shift[6:0], r_sda_s2};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rw       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rw       <= w_rw_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_sda_oe_nxt   = r_sda_oe;
        w_busy_nxt     = r_busy;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_rw_nxt       = r_rw;
        w_tx_next      = 1'b0;
        if (w_stop) begin
            w_state_nxt  = ST_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_cnt_nxt    = '0;
        end else if (w_start) begin
            w_state_nxt  = ST_ADDR;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_cnt_nxt    = '0;
        end else begin
            case (r_state)
                ST_ADDR: if (w_scl_rise) begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        if (r_shift[6:0] == ADDR) begin
                            w_state_nxt = ST_ADDR_ACK;
                            w_busy_nxt  = 1'b1;
                            w_rw_nxt    = r_sda_s2;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                        end
                    end
                end
                // ACK slots: first SCL fall drives low, second fall releases and moves on
                ST_ADDR_ACK: if (w_scl_fall) begin
                    if (!r_sda_oe) begin
                        w_sda_oe_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = '0;
                        if (r_rw) begin
                            w_tx_next    = 1'b1;
                            w_shift_nxt  = tx_data;
                            w_sda_oe_nxt = ~tx_data[7];
                            w_state_nxt  = ST_RD_DATA;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: if (w_scl_rise) begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_rx_data_nxt  = w_shift_in;
                        w_rx_valid_nxt = 1'b1;
                        w_state_nxt    = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: if (w_scl_fall) begin
                    if (!r_sda_oe) begin
                        w_sda_oe_nxt = 1'b1;
                    end else begin
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: if (w_scl_fall) begin
                    if (r_cnt == 3'd7) begin
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_RD_ACK;
                    end else begin
                        w_shift_nxt  = {r_shift[6:0], 1'b0};
                        w_sda_oe_nxt = ~r_shift[6];
                        w_cnt_nxt    = r_cnt + 3'd1;
                    end
                end
                ST_RD_ACK: begin
                    if (w_scl_rise && r_sda_s2) begin
                        w_state_nxt = ST_IGNORE;
                    end else if (w_scl_fall) begin
                        w_tx_next    = 1'b1;
                        w_shift_nxt  = tx_data;
                        w_sda_oe_nxt = ~tx_data[7];
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_next  = w_tx_next;
    assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_target_if.sv
// Directed bench for i2c_target_if: a bit-banged controller drives the open-drain bus
// and every observation is compared against hand-computed values.
module tb_i2c_target_if;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst, scl, m_sda;
    logic       sda_bus;
    logic [7:0] tx_data;
    logic       sda_oe, rx_valid, tx_next, busy;
    logic [7:0] rx_data;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int rxv_cnt = 0, txn_cnt = 0, oe_cnt = 0;
    logic [7:0] rx_last = 8'h00;

    always #5 clk = ~clk;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_target_if #(.ADDR(7'h50)) dut (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_next(tx_next),
        .tx_data(tx_data), .busy(busy)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            rx_last = rx_data;
        end
        if (tx_next) txn_cnt++;
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quarter;
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; quarter;
        scl = 1'b1;   quarter;
        m_sda = 1'b0; quarter;
        scl = 1'b0;   quarter;
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; quarter;
        scl = 1'b1;   quarter;
        m_sda = 1'b1; quarter;
    endtask

    task automatic bit_slot(input logic b, output logic s);
        m_sda = b; quarter;
        scl = 1'b1; quarter;
        s = sda_bus; quarter;
        scl = 1'b0; quarter;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_low);
        logic s;
        for (int i = 7; i >= 0; i--) bit_slot(d[i], s);
        bit_slot(1'b1, s);
        ack_low = ~s;
    endtask

    // tx_data is scrambled mid-byte to show it is only taken on tx_next
    task automatic read_byte(input logic nack, input logic [7:0] nxt, output logic [7:0] q);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_slot(1'b1, s);
            q[i] = s;
            if (i == 4) tx_data = 8'hC3;
        end
        tx_data = nxt;
        bit_slot(nack, s);
    endtask

    initial begin
        logic       ack;
        logic [7:0] q;
        int         r0, t0, o0;

        rst = 1'b1; scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_sda_oe", {7'd0, sda_oe}, 8'h00);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("rst_tx_next", {7'd0, tx_next}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        rst = 1'b0;
        quarter;

        // 1: write 0x3C
        r0 = rxv_cnt;
        i2c_start;
        write_byte(8'hA0, ack); check("t1_addr_ack", {7'd0, ack}, 8'h01);
        check("t1_busy", {7'd0, busy}, 8'h01);
        write_byte(8'h3C, ack); check("t1_data_ack", {7'd0, ack}, 8'h01);
        check("t1_rxv_count", 8'(rxv_cnt - r0), 8'h01);
        check("t1_rx_data", rx_last, 8'h3C);
        i2c_stop;
        check("t1_busy_stop", {7'd0, busy}, 8'h00);
        check("t1_oe_stop", {7'd0, sda_oe}, 8'h00);

        // 2: foreign address 0x52
        r0 = rxv_cnt; o0 = oe_cnt;
        i2c_start;
        write_byte(8'hA4, ack); check("t2_addr_nack", {7'd0, ack}, 8'h00);
        write_byte(8'h12, ack); check("t2_d1_nack", {7'd0, ack}, 8'h00);
        write_byte(8'h34, ack); check("t2_d2_nack", {7'd0, ack}, 8'h00);
        check("t2_rxv_count", 8'(rxv_cnt - r0), 8'h00);
        check("t2_oe_cycles", 8'(oe_cnt - o0), 8'h00);
        check("t2_busy", {7'd0, busy}, 8'h00);
        i2c_stop;

        // 3: read 0xA5 (ACK) then 0x0F (NACK)
        t0 = txn_cnt; tx_data = 8'hA5;
        i2c_start;
        write_byte(8'hA1, ack); check("t3_addr_ack", {7'd0, ack}, 8'h01);
        read_byte(1'b0, 8'h0F, q); check("t3_byte1", q, 8'hA5);
        read_byte(1'b1, 8'h99, q); check("t3_byte2", q, 8'h0F);
        check("t3_tx_next_count", 8'(txn_cnt - t0), 8'h02);
        check("t3_oe_after_nack", {7'd0, sda_oe}, 8'h00);
        check("t3_busy_before_stop", {7'd0, busy}, 8'h01);
        o0 = oe_cnt;
        write_byte(8'h00, ack); check("t3_ignore_ack", {7'd0, ack}, 8'h00);
        check("t3_ignore_oe", 8'(oe_cnt - o0), 8'h00);
        i2c_stop;
        check("t3_busy_stop", {7'd0, busy}, 8'h00);

        // 4: write 0x11, repeated START, read 0x5A
        i2c_start;
        write_byte(8'hA0, ack); check("t4_addr_ack", {7'd0, ack}, 8'h01);
        write_byte(8'h11, ack); check("t4_data_ack", {7'd0, ack}, 8'h01);
        check("t4_rx_data", rx_last, 8'h11);
        i2c_start;
        check("t4_rs_busy", {7'd0, busy}, 8'h00);
        check("t4_rs_oe", {7'd0, sda_oe}, 8'h00);
        tx_data = 8'h5A;
        write_byte(8'hA1, ack); check("t4_addr2_ack", {7'd0, ack}, 8'h01);
        read_byte(1'b1, 8'h00, q); check("t4_read", q, 8'h5A);
        i2c_stop;

        // 5: STOP after 4 bits, then write 0x77
        i2c_start;
        write_byte(8'hA0, ack); check("t5_addr_ack", {7'd0, ack}, 8'h01);
        r0 = rxv_cnt;
        bit_slot(1'b1, ack); bit_slot(1'b0, ack); bit_slot(1'b1, ack); bit_slot(1'b1, ack);
        i2c_stop;
        check("t5_partial_rxv", 8'(rxv_cnt - r0), 8'h00);
        check("t5_oe", {7'd0, sda_oe}, 8'h00);
        check("t5_busy", {7'd0, busy}, 8'h00);
        i2c_start;
        write_byte(8'hA0, ack); check("t5_addr2_ack", {7'd0, ack}, 8'h01);
        write_byte(8'h77, ack); check("t5_data_ack", {7'd0, ack}, 8'h01);
        i2c_stop;
        check("t5_rxv", 8'(rxv_cnt - r0), 8'h01);
        check("t5_rx_data", rx_last, 8'h77);

        // 6: reset while driving SDA low during a read
        tx_data = 8'h00;
        i2c_start;
        write_byte(8'hA1, ack); check("t6_addr_ack", {7'd0, ack}, 8'h01);
        check("t6_oe_before_rst", {7'd0, sda_oe}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_oe", {7'd0, sda_oe}, 8'h00);
        check("t6_rst_busy", {7'd0, busy}, 8'h00);
        rst = 1'b0;
        quarter;
        r0 = rxv_cnt;
        write_byte(8'hA0, ack); check("t6_no_start_ack", {7'd0, ack}, 8'h00);
        write_byte(8'h55, ack); check("t6_no_start_data", {7'd0, ack}, 8'h00);
        check("t6_no_rxv", 8'(rxv_cnt - r0), 8'h00);
        i2c_start;
        write_byte(8'hA0, ack); check("t6_reengage_ack", {7'd0, ack}, 8'h01);
        write_byte(8'h42, ack);
        i2c_stop;
        check("t6_rx_data", rx_last, 8'h42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
